present_sbox_layer_ctrl: RTL and testbench

//  Serialised PRESENT substitution-layer controller.
//  - Applies the existing 4-bit PRESENT S-box to a 4*NIBBLES-bit state, one nibble per cycle.
//  - Uses a single S-box instance (area-minimal datapath).
//  - Optional shuffling countermeasure: processing starts at a random nibble index and wraps modulo NIBBLES.
//  - Sits between the round-key XOR and the pLayer in a serial PRESENT core.
//  - Uses a valid/ready handshake on both sides.

---
 rtl/present_pkg.sv | 15 +
 rtl/present.sv | 30 +++
 rtl/present_sbox_layer_ctrl.sv | 94 +++++++++
 tb/tb_present_sbox_layer_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared definitions for the serialised PRESENT substitution layer:
// controller state encoding and state-width helper.
package present_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    function automatic int unsigned state_w(input int unsigned nibbles);
        return 4 * nibbles;
    endfunction

endpackage

// File: rtl/present.sv
// PRESENT 4-bit S-box (x -> s), purely combinational.
module present (
    input  logic [3:0] x,
    output logic [3:0] s
);

    always_comb begin
        s = 4'h0;
        unique case (x)
            4'h0: s = 4'hC;
            4'h1: s = 4'h5;
            4'h2: s = 4'h6;
            4'h3: s = 4'hB;
            4'h4: s = 4'h9;
            4'h5: s = 4'h0;
            4'h6: s = 4'hA;
            4'h7: s = 4'hD;
            4'h8: s = 4'h3;
            4'h9: s = 4'hE;
            4'hA: s = 4'hF;
            4'hB: s = 4'h8;
            4'hC: s = 4'h4;
            4'hD: s = 4'h7;
            4'hE: s = 4'h1;
            4'hF: s = 4'h2;
            default: s = 4'h0;
        endcase
    end

endmodule

// File: rtl/present_sbox_layer_ctrl.sv
// Serialised PRESENT substitution layer: one shared S-box, one nibble per cycle,
// optional random start index (shuffling), valid/ready on both sides.
module present_sbox_layer_ctrl
    import present_pkg::*;
#(
    parameter int unsigned NIBBLES = 16,
    parameter bit          SHUFFLE = 1'b1,
    localparam int unsigned STATE_W = state_w(NIBBLES),
    localparam int unsigned IDX_W   = $clog2(NIBBLES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic [IDX_W-1:0]   rnd_start,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy,
    output logic [IDX_W-1:0]   nib_idx
);

    ctrl_state_t fsm, fsm_next;

    logic [STATE_W-1:0] state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   cnt;
    logic [3:0]         sbox_in;
    logic [3:0]         sbox_out;
    logic               accept;
    logic               last;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == IDX_W'(NIBBLES - 1));

    // NIBBLES:1 mux feeding the single S-box instance.
    assign sbox_in = state[{idx, 2'b00} +: 4];

    present u_sbox (
        .x (sbox_in),
        .s (sbox_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm;
        unique case (fsm)
            IDLE: if (accept) fsm_next = SUB;
            SUB:  if (last) fsm_next = DONE;
            DONE: if (out_ready) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (accept) begin
                        state <= in_data;
                        idx   <= SHUFFLE ? rnd_start : '0;
                        cnt   <= '0;
                    end
                end
                SUB: begin
                    // 1:NIBBLES write-back demux; idx wraps naturally as NIBBLES is a power of two.
                    state[{idx, 2'b00} +: 4] <= sbox_out;
                    idx <= idx + 1'b1;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm == SUB) || (fsm == DONE);
    assign out_data  = out_valid ? state : '0;
    assign nib_idx   = (fsm == SUB) ? idx : '0;

endmodule

// File: tb/tb_present_sbox_layer_ctrl.sv
// Bench: a shuffling and a non-shuffling controller driven in lockstep and checked
// against a table-lookup model of the PRESENT substitution layer.
module tb_present_sbox_layer_ctrl;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_data;
    logic [3:0]  rnd_start;
    logic        out_ready;

    logic        in_ready_s, out_valid_s, busy_s;
    logic [63:0] out_data_s;
    logic [3:0]  nib_idx_s;
    logic        in_ready_z, out_valid_z, busy_z;
    logic [63:0] out_data_z;
    logic [3:0]  nib_idx_z;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    present_sbox_layer_ctrl #(.NIBBLES(16), .SHUFFLE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .rnd_start(rnd_start), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .busy(busy_s), .nib_idx(nib_idx_s)
    );

    present_sbox_layer_ctrl #(.NIBBLES(16), .SHUFFLE(1'b0)) dut_z (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_z),
        .in_data(in_data), .rnd_start(rnd_start), .out_valid(out_valid_z),
        .out_ready(out_ready), .out_data(out_data_z), .busy(busy_z), .nib_idx(nib_idx_z)
    );

    logic [3:0] sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                  4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    function automatic logic [63:0] ref_sub(input logic [63:0] x);
        logic [63:0] r = '0;
        for (int i = 0; i < N; i++) r[4*i +: 4] = sbox_tab[x[4*i +: 4]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] din;
        logic [3:0]  start;
        logic [63:0] exp;
        int          hold;
    } vec_t;

    vec_t vecs[$];

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"},  {in_ready_s, in_ready_z},   2'b11);
        chk({tag, "_out_valid"}, {out_valid_s, out_valid_z}, 2'b00);
        chk({tag, "_busy"},      {busy_s, busy_z},           2'b00);
        chk({tag, "_out_data_s"}, out_data_s, 64'h0);
        chk({tag, "_out_data_z"}, out_data_z, 64'h0);
        chk({tag, "_nib_idx"},   {nib_idx_s, nib_idx_z},     8'h00);
    endtask

    task automatic run_block(input logic [63:0] din, input logic [3:0] start,
                             input logic [63:0] exp, input int hold);
        int t = 0;
        while (!(in_ready_s && in_ready_z) && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("ready_before_accept", {in_ready_s, in_ready_z}, 2'b11);
        in_data   = din;
        rnd_start = start;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_data   = {$urandom, $urandom};
        rnd_start = 4'($urandom);
        in_valid  = (hold > 0);
        for (int k = 0; k < N; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            chk("sub_nib_idx_shuffle", nib_idx_s, (start + k) % N);
            chk("sub_nib_idx_plain",   nib_idx_z, k);
            chk("sub_out_valid",       {out_valid_s, out_valid_z}, 2'b00);
            chk("sub_out_data_hidden", out_data_s | out_data_z, 64'h0);
            chk("sub_busy_ready",      {busy_s, busy_z, in_ready_s, in_ready_z}, 4'b1100);
        end
        @(posedge clk); #1;
        chk("done_out_valid",   {out_valid_s, out_valid_z}, 2'b11);
        chk("done_out_data_s",  out_data_s, exp);
        chk("done_out_data_z",  out_data_z, exp);
        chk("done_ready_busy",  {in_ready_s, in_ready_z, busy_s, busy_z}, 4'b0011);
        chk("done_nib_idx",     {nib_idx_s, nib_idx_z}, 8'h00);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", {out_valid_s, out_valid_z}, 2'b11);
            chk("hold_out_data",  out_data_s, exp);
            chk("hold_in_ready",  {in_ready_s, in_ready_z}, 2'b00);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_idle("after_out");
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        rnd_start = '0;
        out_ready = 1'b0;

        // Reset raised mid-cycle must clear outputs without waiting for a clock edge.
        #12;
        rst = 1'b1;
        #1;
        check_idle("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        vecs.push_back('{64'h0123456789ABCDEF, 4'h0, 64'hC56B90AD3EF84712, 0});
        vecs.push_back('{64'h0123456789ABCDEF, 4'hA, 64'hC56B90AD3EF84712, 0});
        vecs.push_back('{64'h0123456789ABCDEF, 4'h5, 64'hC56B90AD3EF84712, 0});
        vecs.push_back('{64'hFFFFFFFFFFFFFFFF, 4'h3, 64'h2222222222222222, 5});
        vecs.push_back('{64'h0000000000000000, 4'hF, 64'hCCCCCCCCCCCCCCCC, 0});
        for (int r = 0; r < 6; r++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            vecs.push_back('{d, 4'($urandom_range(15, 0)), ref_sub(d), int'($urandom_range(2, 0))});
        end

        foreach (vecs[i]) run_block(vecs[i].din, vecs[i].start, vecs[i].exp, vecs[i].hold);

        // Abort mid-SUB: reset after cnt reaches 7, then a fresh block must be clean.
        in_data   = 64'h0123456789ABCDEF;
        rnd_start = 4'h2;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("abort_pre_nib_idx", nib_idx_s, 4'h9);
        #2;
        rst = 1'b1;
        #1;
        check_idle("abort");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_block(64'h0, 4'h6, 64'hCCCCCCCCCCCCCCCC, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
